pdp_fp17_4lane_accum: RTL

Initiator-side controller for the 4-lane fp17 pooling adder in the PDP datapath. It accepts a stream of packed 4-lane fp17 vectors and folds each window of N vectors into one running sum. The running sum is operand a and the incoming vector is operand b of the external adder. The adder result is written back to the running sum, and the final 4-lane sum is emitted once per window. The block contains no arithmetic: all floating-point addition happens in the adder it drives through its valid/ready input and output channels.

---
 rtl/pdp_accum_pkg.sv | 21 ++
 rtl/pdp_fp17_4lane_accum.sv | 99 +++++++++
 2 files changed

// File: rtl/pdp_accum_pkg.sv
// Shared types and sizes for the PDP fp17 4-lane pooling accumulator.
// Lanes are packed lane i at bits [17i+16:17i] of a VEC_W-bit vector.
package pdp_accum_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 17;
  localparam int VEC_W  = LANES * LANE_W;
  localparam int CNT_W  = 4;

  // One extra bit so a full 16-vector window compares without wrapping.
  localparam logic [CNT_W:0] CNT_ONE = (CNT_W + 1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    OUT
  } state_e;

endpackage

// File: rtl/pdp_fp17_4lane_accum.sv
// Folds windows of 1..16 packed fp17 vectors into one sum through an external
// pipelined adder; one adder transaction is in flight at a time.
module pdp_fp17_4lane_accum
  import pdp_accum_pkg::*;
(
  input  logic             autosa_core_clk,
  input  logic             autosa_core_rst,
  input  logic [CNT_W-1:0] cfg_kernel_num,
  input  logic             din_pvld,
  output logic             din_prdy,
  input  logic [VEC_W-1:0] din_pd,
  output logic [VEC_W-1:0] add_in_a,
  output logic [VEC_W-1:0] add_in_b,
  output logic             add_in_pvld,
  input  logic             add_in_prdy,
  input  logic [VEC_W-1:0] add_out_dp,
  input  logic             add_out_pvld,
  output logic             add_out_prdy,
  output logic [VEC_W-1:0] dout_pd,
  output logic             dout_pvld,
  input  logic             dout_prdy,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] sum_q, sum_d;
  logic [VEC_W-1:0] b_q, b_d;
  logic [CNT_W:0]   cnt_q, cnt_d;
  logic [CNT_W:0]   n_q, n_d;
  logic [CNT_W:0]   cnt_inc;

  assign cnt_inc = cnt_q + CNT_ONE;

  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    case (state_q)
      IDLE: begin
        if (din_pvld) begin
          sum_d   = din_pd;
          cnt_d   = CNT_ONE;
          n_d     = {1'b0, cfg_kernel_num} + CNT_ONE;
          state_d = (cfg_kernel_num == '0) ? OUT : FETCH;
        end
      end
      FETCH: begin
        if (din_pvld) begin
          b_d     = din_pd;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (add_in_prdy) state_d = WAIT;
      end
      WAIT: begin
        if (add_out_pvld) begin
          sum_d   = add_out_dp;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == n_q) ? OUT : FETCH;
        end
      end
      OUT: begin
        if (dout_prdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on registered state only.
  assign din_prdy     = (state_q == IDLE) || (state_q == FETCH);
  assign add_in_pvld  = (state_q == ISSUE);
  assign add_out_prdy = (state_q == WAIT);
  assign dout_pvld    = (state_q == OUT);
  assign busy         = (state_q != IDLE);

  assign add_in_a = sum_q;
  assign add_in_b = b_q;
  assign dout_pd  = sum_q;

endmodule
